// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for the pipe_skid_reg stage: an upstream (in_*) channel
// and a downstream (out_*) channel, each a valid/ready/data triple.
//
// Valid/ready rule for both channels: a transfer happens on a rising clk edge
// exactly when valid and ready are both 1 before that edge. Once valid is
// asserted, the producer holds valid and data stable until the transfer.
// Ready may change freely and never depends combinationally on valid.
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Environment side: drives upstream payload and downstream ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Stage side: accepts upstream payload and presents it downstream.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a single skid entry (ID/EX style stage).
// All outputs toward the bus are registered. When the stage is empty it
// presents NOP_VALUE so the downstream never sees a stale payload.
// bubble_cnt counts cycles in which downstream was ready but got no entry.
module pipe_skid_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic              in_fire;
    logic              out_fire;

    // Both handshakes are judged on the registered ready/valid seen before the edge.
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign dbg_state     = state;

    // Stage FSM: main_q is the output register and holds NOP_VALUE while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            // Redirect: drop both entries; any coincident in_fire is lost too.
            state       <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state       <= FULL;
                        main_q      <= bus.in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= bus.in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry and stop upstream.
                        state      <= SKID;
                        skid_q     <= bus.in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        main_q      <= NOP_VALUE;
                        out_valid_q <= 1'b0;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state      <= FULL;
                        main_q     <= skid_q;
                        skid_q     <= NOP_VALUE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    main_q      <= NOP_VALUE;
                    skid_q      <= NOP_VALUE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of bubbles offered to a ready downstream; flush does not touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid_q && bus.out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a randomized run checked
// against a queue-based model of the stage (at most two held entries, oldest
// presented downstream).
module tb_pipe_skid_reg;

    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_ready = 1'b0;

    logic [15:0] bubble_cnt;
    logic [1:0]  dbg_state;
    logic [1:0]  bubble_cnt2;
    logic [1:0]  dbg_state2;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) bus  ();
    pipe_skid_reg_if #(.DATA_W(DATA_W)) bus2 ();

    assign bus.in_valid   = in_valid;
    assign bus.in_data    = in_data;
    assign bus.out_ready  = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data;
    assign bus2.out_ready = out_ready;

    pipe_skid_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt),
        .dbg_state  (dbg_state)
    );

    // Narrow-counter instance for the saturation scenario.
    pipe_skid_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus2),
        .bubble_cnt (bubble_cnt2),
        .dbg_state  (dbg_state2)
    );

    // Scoreboard / reference model
    logic [DATA_W-1:0] exp_q[$];
    logic [15:0]       mdl_cnt = '0;
    int                checks  = 0;
    int                errors  = 0;

    // Driver: apply one clock edge and advance the model by the same edge.
    task automatic cycle();
        int   sz;
        logic m_in_fire;
        logic m_out_fire;
        sz         = exp_q.size();
        m_in_fire  = in_valid && (sz < 2);
        m_out_fire = out_ready && (sz > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            mdl_cnt = '0;
        end else begin
            if (sz == 0 && out_ready && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_out_fire) void'(exp_q.pop_front());
                if (m_in_fire) exp_q.push_back(in_data);
            end
        end
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_data   = 32'hBAD0_BAD0;
        out_ready = 1'b1;
        rst       = 1'b1;
        cycle();
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== NOP) begin errors++; $display("FAIL reset_out_data: got %h want %h", bus.out_data, NOP); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
        rst = 1'b0;
        idle_inputs();
        // Fill both entries, then reset mid-operation: nothing may survive.
        in_valid = 1'b1; in_data = 32'h0000_00A1; cycle();
        in_data  = 32'h0000_00A2; cycle();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_fill_in_ready: got %0b want 0", bus.in_ready); end
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0; out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_op: got v=%0b d=%h r=%0b want v=0 d=%h r=1", bus.out_valid, bus.out_data, bus.in_ready, NOP);
        end
        out_ready = 1'b1; cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
            errors++; $display("FAIL reset_no_emit: got v=%0b d=%h want v=0 d=%h", bus.out_valid, bus.out_data, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) begin
            errors++; $display("FAIL single_present: got v=%0b d=%h want v=1 d=00000011", bus.out_valid, bus.out_data);
        end
        cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
            errors++; $display("FAIL single_drain: got v=%0b d=%h want v=0 d=%h", bus.out_valid, bus.out_data, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i);
            cycle();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(i) || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_%0d: got v=%0b d=%h r=%0b want v=1 d=%h r=1", i, bus.out_valid, bus.out_data, bus.in_ready, DATA_W'(i));
            end
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
            errors++; $display("FAIL stream_end: got v=%0b d=%h want v=0 d=%h", bus.out_valid, bus.out_data, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; cycle();
        in_data = 32'hB; cycle();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_skid: got v=%0b d=%h r=%0b want v=1 d=0000000a r=0", bus.out_valid, bus.out_data, bus.in_ready);
        end
        // Upstream keeps offering while not ready; this entry must not be taken.
        in_data = 32'hEE; cycle();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
            errors++; $display("FAIL bp_hold: got d=%h r=%0b want d=0000000a r=0", bus.out_data, bus.in_ready);
        end
        in_valid = 1'b0; out_ready = 1'b1; cycle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second: got v=%0b d=%h r=%0b want v=1 d=0000000b r=1", bus.out_valid, bus.out_data, bus.in_ready);
        end
        cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got v=%0b d=%h r=%0b want v=0 d=%h r=1", bus.out_valid, bus.out_data, bus.in_ready, NOP);
        end
        idle_inputs();
    endtask

    task automatic test_flush_skid();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; cycle();
        in_data = 32'hB; cycle();
        flush = 1'b1; in_data = 32'hC; cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got v=%0b d=%h r=%0b want v=0 d=%h r=1", bus.out_valid, bus.out_data, bus.in_ready, NOP);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
                errors++; $display("FAIL flush_no_emit_%0d: got v=%0b d=%h want v=0 d=%h", i, bus.out_valid, bus.out_data, NOP);
            end
        end
        idle_inputs();
    endtask

    task automatic test_bubble_sat();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (bubble_cnt2 !== exp_cnt[i]) begin
                errors++; $display("FAIL bubble_sat_%0d: got %0d want %0d", i, bubble_cnt2, exp_cnt[i]);
            end
        end
        checks++; if (bubble_cnt !== 16'd5) begin
            errors++; $display("FAIL bubble_wide: got %0d want 5", bubble_cnt);
        end
        // A flush while idle must still count the bubble.
        flush = 1'b1; cycle(); flush = 1'b0;
        checks++; if (bubble_cnt !== 16'd6) begin
            errors++; $display("FAIL bubble_flush: got %0d want 6", bubble_cnt);
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        checks++; if (bubble_cnt2 !== 2'd0 || bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL bubble_reset: got %0d/%0d want 0/0", bubble_cnt2, bubble_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_data;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
            exp_data = (exp_q.size() > 0) ? exp_q[0] : NOP;
            checks++; if (bus.out_valid !== (exp_q.size() > 0)) begin
                errors++; $display("FAIL rand_out_valid@%0d: got %0b want %0b", n, bus.out_valid, exp_q.size() > 0);
            end
            checks++; if (bus.out_data !== exp_data) begin
                errors++; $display("FAIL rand_out_data@%0d: got %h want %h", n, bus.out_data, exp_data);
            end
            checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin
                errors++; $display("FAIL rand_in_ready@%0d: got %0b want %0b", n, bus.in_ready, exp_q.size() < 2);
            end
            checks++; if (bubble_cnt !== mdl_cnt) begin
                errors++; $display("FAIL rand_bubble_cnt@%0d: got %0d want %0d", n, bubble_cnt, mdl_cnt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush_skid();
        test_bubble_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32; width of the carried payload (the full decoded-instruction bundle in the ID/EX use).
REQ-002 Parameter NOP_VALUE, default all-zero DATA_W; payload driven on out_data whenever no valid entry is presented (bubble encoding).
REQ-003 Parameter CNT_W, default 16; width of the bubble counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held entries (branch/jump redirect).
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  stage can accept; registered.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry; registered.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  payload to downstream; registered.
REQ-013 bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0 and out_ready=1.

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; each evaluated on the pre-edge values.
REQ-015 Storage: one main entry (drives out_data) and one skid entry; states EMPTY, FULL, SKID.
REQ-016 EMPTY: in_fire -> FULL, main <= in_data; otherwise stay EMPTY.
REQ-017 FULL: in_fire & out_fire -> FULL, main <= in_data; in_fire & !out_fire -> SKID, skid <= in_data; !in_fire & out_fire -> EMPTY; neither -> FULL, main unchanged.
REQ-018 SKID: out_fire -> FULL, main <= skid; otherwise hold both entries; in_fire cannot occur (in_ready=0).
REQ-019 out_valid = 1 in FULL and SKID, 0 in EMPTY.
REQ-020 out_data = main in FULL/SKID; = NOP_VALUE in EMPTY (bubble injected, never stale payload).
REQ-021 in_ready = 1 in EMPTY and FULL, 0 in SKID; updated on the same edge as the state.
REQ-022 Latency: in_fire at edge N makes the payload visible on out_data after edge N in EMPTY; throughput one entry per cycle with out_ready held 1.
REQ-023 Order: entries leave in acceptance order; no entry is duplicated or lost except by flush.
REQ-024 flush=1: next state EMPTY, out_valid <= 0, out_data <= NOP_VALUE, in_ready <= 1; a coincident in_fire is discarded; a coincident out_fire completes downstream as normal.
REQ-025 Priority: rst > flush > handshake transitions.
REQ-026 bubble_cnt increments by 1 each cycle out_valid=0 & out_ready=1; holds at 2^CNT_W-1; unaffected by flush.

Reset
REQ-027 rst=1 at an edge: state EMPTY, out_valid=0, out_data=NOP_VALUE, in_ready=1, skid entry cleared to NOP_VALUE, bubble_cnt=0.
REQ-028 Reset mid-operation discards main and skid entries without emitting them; in_valid/out_ready ignored during reset cycles.

Verification
REQ-029 Reset then in_valid=1, in_data=0x11, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0x11; following cycle out_valid=0, out_data=NOP_VALUE.
REQ-030 Stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, in_ready constantly 1.
REQ-031 FULL holding 0xA, out_ready=0, push 0xB -> in_ready=0, out_data stays 0xA; out_ready=1 -> 0xA then 0xB emitted, in_ready back to 1.
REQ-032 SKID state holding 0xA/0xB, flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; 0xA, 0xB, 0xC never emitted.
REQ-033 CNT_W=2, idle with out_ready=1 for 5 cycles -> bubble_cnt 1,2,3,3,3; rst -> 0.
REQ-034 Random in_valid/out_ready/flush vs. scoreboard model -> order and no-loss rules hold; out_data equals NOP_VALUE whenever out_valid=0.
